// File: rtl/mmcm_drp_pkg.sv
// Shared types and widths for the MMCM DRP reconfiguration sequencer.
package mmcm_drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_LOCK
  } drp_state_t;

  typedef struct packed {
    logic [DRP_ADDR_W-1:0] addr;
    logic [DRP_DATA_W-1:0] mask;
    logic [DRP_DATA_W-1:0] data;
  } drp_entry_t;

endpackage

// File: rtl/mmcm_drp_rom.sv
// Fixed table of MMCM DRP register updates, one row set per clock configuration.
module mmcm_drp_rom
  import mmcm_drp_pkg::*;
#(
  parameter int NUM_CFG = 4,
  parameter int ENTRIES = 8
) (
  input  logic [$clog2(NUM_CFG)-1:0] cfg,
  input  logic [$clog2(ENTRIES)-1:0] idx,
  output drp_entry_t                 entry
);

  logic [1:0] csel;
  logic [2:0] esel;
  logic [5:0] half;

  always_comb begin
    csel = 2'(cfg);
    esel = 3'(idx);
    // CLKOUT0 high/low time; divide ratios 4, 2, 8, 10
    case (csel)
      2'd0:    half = 6'd2;
      2'd1:    half = 6'd1;
      2'd2:    half = 6'd4;
      default: half = 6'd5;
    endcase
    entry = '0;
    case (esel)
      3'd0: entry = '{addr: 7'h08, mask: 16'h1000, data: {4'h0, half, half}};
      3'd1: entry = '{addr: 7'h09, mask: 16'h8000, data: 16'h0000};
      3'd2: entry = '{addr: 7'h0A, mask: 16'h1000,
                      data: {4'h0, half[4:0], 1'b0, half[4:0], 1'b0}};
      3'd3: entry = '{addr: 7'h0B, mask: 16'h8000, data: 16'h0000};
      3'd4: entry = '{addr: 7'h14, mask: 16'h1000, data: 16'h0104};
      3'd5: entry = '{addr: 7'h15, mask: 16'h8000, data: 16'h0000};
      3'd6: entry = '{addr: 7'h16, mask: 16'hC000, data: 16'h1041};
      default: entry = '{addr: 7'h18, mask: 16'hFC00, data: 16'h03E8};
    endcase
  end

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Run-time MMCM reconfiguration: holds MMCM in reset, read-modify-writes DRP registers, waits for lock.
// Optional DRP_TIMEOUT_EN: bounds each wait for drp_drdy to DRDY_TIMEOUT cycles.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int NUM_CFG      = 4,
  parameter int ENTRIES      = 8,
  parameter int LOCK_TIMEOUT = 65535
`ifdef DRP_TIMEOUT_EN
  , parameter int DRDY_TIMEOUT = 255
`endif
) (
  input  logic                          CLK100MHZ,
  input  logic                          CPU_RESETN,
  input  logic [$clog2(NUM_CFG)-1:0]    cfg_sel,
  input  logic                          cfg_req,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          drp_den,
  output logic                          drp_dwe,
  output logic [DRP_ADDR_W-1:0]         drp_daddr,
  output logic [DRP_DATA_W-1:0]         drp_di,
  input  logic [DRP_DATA_W-1:0]         drp_do,
  input  logic                          drp_drdy,
  output logic                          mmcm_rst,
  input  logic                          mmcm_locked
);

  localparam int CW = $clog2(NUM_CFG);
  localparam int IW = $clog2(ENTRIES);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  drp_state_t      state;
  logic [CW-1:0]   cfg_q;
  logic [IW-1:0]   idx;
  logic [LW-1:0]   lcnt;
  logic [1:0]      lsync;
  logic            locked_s;
  drp_entry_t      entry;
`ifdef DRP_TIMEOUT_EN
  localparam int DW = $clog2(DRDY_TIMEOUT + 1);
  logic [DW-1:0]   dcnt;
`endif

  assign locked_s = lsync[1];

  mmcm_drp_rom #(
    .NUM_CFG(NUM_CFG),
    .ENTRIES(ENTRIES)
  ) u_rom (
    .cfg  (cfg_q),
    .idx  (idx),
    .entry(entry)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) lsync <= '0;
    else             lsync <= {lsync[0], mmcm_locked};
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= S_IDLE;
      cfg_q     <= '0;
      idx       <= '0;
      lcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
      mmcm_rst  <= 1'b0;
`ifdef DRP_TIMEOUT_EN
      dcnt      <= '0;
`endif
    end else begin
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: if (cfg_req) begin
          cfg_q    <= cfg_sel;
          idx      <= '0;
          err      <= 1'b0;
          busy     <= 1'b1;
          mmcm_rst <= 1'b1;
          state    <= S_RST;
        end
        S_RST: begin
          mmcm_rst <= 1'b1;
          state    <= S_RD;
        end
        // den is registered here, so the strobe lines up with the first wait cycle
        S_RD: begin
          drp_den   <= 1'b1;
          drp_daddr <= entry.addr;
`ifdef DRP_TIMEOUT_EN
          dcnt      <= '0;
`endif
          state     <= S_RD_WAIT;
        end
        S_RD_WAIT: if (drp_drdy) begin
          drp_di <= (drp_do & entry.mask) | (entry.data & ~entry.mask);
          state  <= S_WR;
        end
`ifdef DRP_TIMEOUT_EN
        else if (dcnt == DW'(DRDY_TIMEOUT - 1)) begin
          err      <= 1'b1;
          mmcm_rst <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end else dcnt <= dcnt + DW'(1);
`endif
        S_WR: begin
          drp_den <= 1'b1;
          drp_dwe <= 1'b1;
`ifdef DRP_TIMEOUT_EN
          dcnt    <= '0;
`endif
          state   <= S_WR_WAIT;
        end
        S_WR_WAIT: if (drp_drdy) begin
          if (idx == IW'(ENTRIES - 1)) begin
            mmcm_rst <= 1'b0;
            lcnt     <= '0;
            state    <= S_LOCK;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_RD;
          end
        end
`ifdef DRP_TIMEOUT_EN
        else if (dcnt == DW'(DRDY_TIMEOUT - 1)) begin
          err      <= 1'b1;
          mmcm_rst <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end else dcnt <= dcnt + DW'(1);
`endif
        S_LOCK: if (locked_s) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end else if (lcnt == LW'(LOCK_TIMEOUT - 1)) begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end else lcnt <= lcnt + LW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Self-checking bench for mmcm_drp_ctrl with a behavioural DRP register model and lock driver.
module tb_mmcm_drp_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  cfg_sel;
  logic        cfg_req;
  logic        busy, done, err;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di, drp_do;
  logic        drp_drdy;
  logic        mmcm_rst, mmcm_locked;

  int tests = 0;
  int fails = 0;

  mmcm_drp_ctrl #(
    .NUM_CFG(4),
    .ENTRIES(8),
    .LOCK_TIMEOUT(100)
`ifdef DRP_TIMEOUT_EN
    , .DRDY_TIMEOUT(16)
`endif
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .cfg_sel    (cfg_sel),
    .cfg_req    (cfg_req),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_daddr  (drp_daddr),
    .drp_di     (drp_di),
    .drp_do     (drp_do),
    .drp_drdy   (drp_drdy),
    .mmcm_rst   (mmcm_rst),
    .mmcm_locked(mmcm_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
    logic [15:0] rd;
  } txn_t;

  txn_t        log_q[$];
  logic [15:0] regs [128];
  int          lat_min = 2;
  int          lat_max = 2;
  bit          do_ffff = 0;
  bit          mute    = 0;

  // Expected table in clock terms: CLKOUT0 divide per cfg, CLKOUT1 at twice that
  function automatic int divide(input int cfg);
    case (cfg)
      0: return 4;
      1: return 2;
      2: return 8;
      default: return 10;
    endcase
  endfunction

  function automatic logic [6:0] x_addr(input int i);
    logic [6:0] a [8] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15, 7'h16, 7'h18};
    return a[i];
  endfunction

  function automatic logic [15:0] x_mask(input int i);
    logic [15:0] m [8] = '{16'h1000, 16'h8000, 16'h1000, 16'h8000,
                           16'h1000, 16'h8000, 16'hC000, 16'hFC00};
    return m[i];
  endfunction

  function automatic logic [15:0] x_data(input int cfg, input int i);
    int d = divide(cfg);
    case (i)
      0: return {4'h0, 6'(d / 2), 6'(d / 2)};
      2: return {4'h0, 6'(d), 6'(d)};
      4: return 16'h0104;
      6: return 16'h1041;
      7: return 16'h03E8;
      default: return 16'h0000;
    endcase
  endfunction

  // DRP slave: register file, random or all-ones read data, drdy after lat cycles
  initial begin
    txn_t t;
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge clk);
      if (drp_den === 1'b1 && rst_n === 1'b1 && !mute) begin
        t.we   = drp_dwe;
        t.addr = drp_daddr;
        t.di   = drp_di;
        t.rd   = do_ffff ? 16'hFFFF : regs[drp_daddr];
        if (drp_dwe) regs[drp_daddr] = drp_di;
        log_q.push_back(t);
        repeat ($urandom_range(lat_max, lat_min)) @(negedge clk);
        drp_do   = t.we ? 16'($urandom) : t.rd;
        drp_drdy = 1'b1;
        @(negedge clk);
        drp_drdy = 1'b0;
        drp_do   = 16'($urandom);
      end
    end
  end

  task automatic run_sequence(input int cfg, input int lock_delay, input bit inject);
    int   k, nd, lat_k;
    bit   inj, bad_busy;
    txn_t rd, wr;
    logic [15:0] exp;
    log_q.delete();
    mmcm_locked = 1'b0;
    @(negedge clk);
    cfg_sel = 2'(cfg);
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    tests++;
    if ({busy, err, mmcm_rst} !== 3'b101)
      begin fails++; $display("FAIL accept cfg%0d {busy,err,rst} got %b want 101", cfg, {busy, err, mmcm_rst}); end
    k = 0;
    inj = 0;
    while (mmcm_rst === 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
      if (cfg_req) cfg_req = 1'b0;
      else if (inject && !inj && log_q.size() >= 1) begin
        cfg_sel = 2'd2;
        cfg_req = 1'b1;
        inj = 1;
      end
    end
    cfg_req = 1'b0;
    tests++;
    if (k >= 1000) begin fails++; $display("FAIL rst_fall_timeout got %0d cycles want <1000", k); end
    tests++;
    if (log_q.size() != 16)
      begin fails++; $display("FAIL log_size cfg%0d got %0d want 16", cfg, log_q.size()); end
    for (int i = 0; i < 8 && 2 * i + 1 < log_q.size(); i++) begin
      rd = log_q[2*i];
      wr = log_q[2*i+1];
      exp = (rd.rd & x_mask(i)) | (x_data(cfg, i) & ~x_mask(i));
      tests++;
      if ({rd.we, rd.addr} !== {1'b0, x_addr(i)})
        begin fails++; $display("FAIL read[%0d] {we,addr} got %h want %h", i, {rd.we, rd.addr}, {1'b0, x_addr(i)}); end
      tests++;
      if ({wr.we, wr.addr} !== {1'b1, x_addr(i)})
        begin fails++; $display("FAIL write[%0d] {we,addr} got %h want %h", i, {wr.we, wr.addr}, {1'b1, x_addr(i)}); end
      tests++;
      if (wr.di !== exp)
        begin fails++; $display("FAIL write_data[%0d] cfg%0d got %h want %h", i, cfg, wr.di, exp); end
    end
    nd = 0;
    for (int j = 0; j < lock_delay; j++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    @(posedge clk);
    #1 mmcm_locked = 1'b1;
    lat_k = -1;
    bad_busy = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (lat_k < 0) lat_k = j;
        if (busy !== 1'b0) bad_busy = 1;
      end
    end
    tests++;
    if (nd != 1) begin fails++; $display("FAIL done_count got %0d want 1", nd); end
    tests++;
    if (lat_k < 2 || lat_k > 3) begin fails++; $display("FAIL done_latency got %0d want 2..3", lat_k); end
    tests++;
    if (bad_busy) begin fails++; $display("FAIL busy_at_done got 1 want 0"); end
    tests++;
    if ({busy, err} !== 2'b00) begin fails++; $display("FAIL end_state {busy,err} got %b want 00", {busy, err}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++;
    if ({done, err} !== 2'b00) begin fails++; $display("FAIL reset_done_err got %b want 00", {done, err}); end
    tests++;
    if ({drp_den, drp_dwe} !== 2'b00) begin fails++; $display("FAIL reset_den_dwe got %b want 00", {drp_den, drp_dwe}); end
    tests++;
    if ({drp_daddr, drp_di} !== 23'h0) begin fails++; $display("FAIL reset_addr_di got %h want 0", {drp_daddr, drp_di}); end
    tests++;
    if (mmcm_rst !== 1'b0) begin fails++; $display("FAIL reset_mmcm_rst got %b want 0", mmcm_rst); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    do_ffff = 1;
    lat_min = 2;
    lat_max = 2;
    run_sequence(1, 20, 0);
    do_ffff = 0;
  endtask

  task automatic test_random();
    lat_min = 1;
    lat_max = 4;
    for (int n = 0; n < 5; n++)
      run_sequence(int'($urandom_range(3, 0)), int'($urandom_range(40, 0)), 0);
  endtask

  task automatic test_busy_req();
    lat_min = 2;
    lat_max = 4;
    run_sequence(1, 10, 1);
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_req_requeued got %b want 0", busy); end
  endtask

  task automatic test_lock_timeout();
    int k, nd;
    log_q.delete();
    mmcm_locked = 1'b0;
    lat_min = 1;
    lat_max = 3;
    @(negedge clk);
    cfg_sel = 2'd0;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    k = 0;
    while (mmcm_rst === 1'b1 && k < 1000) begin @(negedge clk); k++; end
    tests++;
    if (k >= 1000) begin fails++; $display("FAIL lt_rst_fall_timeout got %0d want <1000", k); end
    k = 0;
    nd = 0;
    while (err !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) nd++;
    end
    tests++;
    if (k < 100 || k > 101) begin fails++; $display("FAIL lock_timeout_cycles got %0d want 100", k); end
    tests++;
    if (nd != 0) begin fails++; $display("FAIL lock_timeout_done got %0d want 0", nd); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL lock_timeout_busy got %b want 0", busy); end
    run_sequence(2, 5, 0);
  endtask

  task automatic test_reset_midop();
    int k;
    log_q.delete();
    mmcm_locked = 1'b0;
    lat_min = 2;
    lat_max = 2;
    @(negedge clk);
    cfg_sel = 2'd1;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    k = 0;
    while (!(drp_den === 1'b1 && drp_dwe === 1'b1) && k < 200) begin @(negedge clk); k++; end
    tests++;
    if (k >= 200) begin fails++; $display("FAIL midop_write_timeout got %0d want <200", k); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, drp_den, drp_dwe, drp_daddr, drp_di} !== 28'h0)
      begin fails++; $display("FAIL midop_async_reset got %h want 0", {busy, done, err, drp_den, drp_dwe, drp_daddr, drp_di}); end
    tests++;
    if (mmcm_rst !== 1'b0) begin fails++; $display("FAIL midop_mmcm_rst got %b want 0", mmcm_rst); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_sequence(3, 10, 0);
  endtask

`ifdef DRP_TIMEOUT_EN
  task automatic test_drdy_timeout();
    int k, n;
    mute = 1;
    mmcm_locked = 1'b0;
    @(negedge clk);
    cfg_sel = 2'd0;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    k = 0;
    while (drp_den !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n = 0;
    while (err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests++;
    if (n < 16 || n > 17) begin fails++; $display("FAIL drdy_timeout_cycles got %0d want 16", n); end
    tests++;
    if ({mmcm_rst, busy, done} !== 3'b000)
      begin fails++; $display("FAIL drdy_timeout_state {rst,busy,done} got %b want 000", {mmcm_rst, busy, done}); end
    mute = 0;
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    cfg_req     = 1'b0;
    cfg_sel     = '0;
    mmcm_locked = 1'b0;
    for (int a = 0; a < 128; a++) regs[a] = 16'($urandom);
    test_reset();
    test_nominal();
    test_random();
    test_busy_req();
    test_lock_timeout();
    test_reset_midop();
`ifdef DRP_TIMEOUT_EN
    test_drdy_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
